// File: rtl/spectrum_pkg.sv
// Shared defaults and writer state encoding for the spectrum frame controller.
package spectrum_pkg;
  localparam int DEF_POINTS = 256;
  localparam int DEF_AW     = 8;
  localparam int DEF_DW     = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;
endpackage

// File: rtl/spectrum_dpram.sv
// Simple dual-port RAM, one write port and one registered read port with enable.
// Address is {bank, index}; contents are deliberately not reset so it maps to block RAM.
module spectrum_dpram
  import spectrum_pkg::*;
#(
  parameter int AW = DEF_AW + 1,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/spectrum_frame_ctrl.sv
// Double-buffered FFT frame capture with bank swap on the vsync rising edge.
// Read latency 1 cycle; writer stalls (mag_ready=0) once a frame is complete until the swap.
module spectrum_frame_ctrl
  import spectrum_pkg::*;
#(
  parameter int POINTS = DEF_POINTS,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mag_valid,
  input  logic [DW-1:0] mag_data,
  input  logic          mag_last,
  output logic          mag_ready,
  input  logic          data_req,
  input  logic          fft_point_done,
  input  logic          out_vsync,
  output logic [AW-1:0] fft_point_cnt,
  output logic [DW-1:0] fft_data,
  output logic          frame_swap,
  output logic [7:0]    drop_cnt
);
  wr_state_t     state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   len_lat, rd_len;
  logic          wb, rd_valid;
  logic          vs_q1, vs_q2, vs_edge;
  logic          accept, swap, hit_q;
  logic [DW-1:0] ram_q;

  assign vs_edge = vs_q1 & ~vs_q2;

  // Swap decision looks at the registered state, so a frame completing in the
  // edge cycle waits for the next edge.
  always_comb begin
    state_nxt = state;
    mag_ready = 1'b0;
    accept    = 1'b0;
    swap      = 1'b0;
    case (state)
      FILL: begin
        mag_ready = 1'b1;
        accept    = mag_valid;
        if (mag_valid && (mag_last || wr_ptr == AW'(POINTS - 1))) state_nxt = FULL;
      end
      FULL: begin
        if (vs_edge) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q1      <= 1'b0;
      vs_q2      <= 1'b0;
      frame_swap <= 1'b0;
      wb         <= 1'b0;
      rd_valid   <= 1'b0;
      wr_ptr     <= '0;
      len_lat    <= '0;
      rd_len     <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      hit_q      <= 1'b0;
    end else begin
      vs_q1      <= out_vsync;
      vs_q2      <= vs_q1;
      frame_swap <= swap;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (state_nxt == FULL) len_lat <= {1'b0, wr_ptr} + {{AW{1'b0}}, 1'b1};
      end
      if (swap) begin
        wb       <= ~wb;
        rd_len   <= len_lat;
        rd_valid <= 1'b1;
        wr_ptr   <= '0;
      end
      if (state == FULL && mag_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (vs_edge)             rd_ptr <= '0;
      else if (fft_point_done) rd_ptr <= rd_ptr + AW'(1);
      // Gate is captured alongside the RAM word so the output holds as a pair.
      if (data_req) hit_q <= rd_valid && ({1'b0, rd_ptr} < rd_len);
    end
  end

  spectrum_dpram #(.AW(AW + 1), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({wb, wr_ptr}),
    .wdata (mag_data),
    .re    (data_req),
    .raddr ({~wb, rd_ptr}),
    .rdata (ram_q)
  );

  assign fft_point_cnt = rd_ptr;
  assign fft_data      = hit_q ? ram_q : '0;
endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// Directed bench for spectrum_frame_ctrl: fill/swap, overflow, short frame, race, reset.
module tb_spectrum_frame_ctrl;
  import spectrum_pkg::*;
  localparam int P = 256;

  logic       clk = 1'b0, rst = 1'b1;
  logic       mag_valid = 1'b0, mag_last = 1'b0, data_req = 1'b0;
  logic       fft_point_done = 1'b0, out_vsync = 1'b0;
  logic [7:0] mag_data = 8'h00;
  logic       mag_ready, frame_swap;
  logic [7:0] fft_point_cnt, fft_data, drop_cnt;

  int n_tests = 0, n_fail = 0, swap_cnt = 0;

  spectrum_frame_ctrl dut (
    .clk(clk), .rst(rst), .mag_valid(mag_valid), .mag_data(mag_data), .mag_last(mag_last),
    .mag_ready(mag_ready), .data_req(data_req), .fft_point_done(fft_point_done),
    .out_vsync(out_vsync), .fft_point_cnt(fft_point_cnt), .fft_data(fft_data),
    .frame_swap(frame_swap), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_swap === 1'b1) swap_cnt++;

  typedef struct { int idx; int exp; } probe_t;
  probe_t probes [9];

  function automatic logic [7:0] val(input int mode, input int i);
    case (mode)
      0: return 8'(i);
      1: return 8'(255 - i);
      2: return 8'(i + 1);
      3: return 8'(i) ^ 8'h5A;
      4: return 8'(i * 3);
      5: return 8'h33;
      default: return 8'hAA;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int n, input int last_at, input int mode);
    for (int i = 0; i < n; i++) begin
      mag_valid = 1'b1;
      mag_data  = val(mode, i);
      mag_last  = (i == last_at);
      tick();
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  task automatic vsync(input string nm, input logic exp_swap);
    out_vsync = 1'b1;
    tick();
    chk({nm, "_pre"}, frame_swap, 0);
    tick();
    chk({nm, "_swap"}, frame_swap, exp_swap);
    out_vsync = 1'b0;
    tick();
    chk({nm, "_post"}, frame_swap, 0);
    tick();
  endtask

  task automatic read_pt(input string nm, input int idx, input int exp);
    data_req = 1'b1;
    tick();
    chk($sformatf("%s_cnt[%0d]", nm, idx), fft_point_cnt, idx);
    chk($sformatf("%s_dat[%0d]", nm, idx), fft_data, exp);
    fft_point_done = 1'b1;
    tick();
    fft_point_done = 1'b0;
  endtask

  task automatic sweep(input string nm, input int mode, input int len);
    for (int i = 0; i < P; i++) read_pt(nm, i, (i < len) ? int'(val(mode, i)) : 0);
    data_req = 1'b1;
    tick();
    chk({nm, "_wrap_cnt"}, fft_point_cnt, 0);
    chk({nm, "_wrap_dat"}, fft_data, (len > 0) ? int'(val(mode, 0)) : 0);
    data_req = 1'b0;
  endtask

  initial begin
    probes[0] = '{0, 1};    probes[1] = '{1, 2};    probes[2] = '{50, 51};
    probes[3] = '{98, 99};  probes[4] = '{99, 100}; probes[5] = '{100, 0};
    probes[6] = '{101, 0};  probes[7] = '{200, 0};  probes[8] = '{255, 0};

    tick(); tick();
    chk("rst_ready", mag_ready, 1);
    chk("rst_cnt", fft_point_cnt, 0);
    chk("rst_data", fft_data, 0);
    chk("rst_swap", frame_swap, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // No frame captured yet: everything reads zero and vsync does not swap.
    sweep("pre", 0, 0);
    vsync("pre_vs", 1'b0);
    chk("pre_swaps", swap_cnt, 0);

    send(P, P - 1, 0);
    chk("fill_ready", mag_ready, 0);
    vsync("fill_vs", 1'b1);
    chk("fill_swaps", swap_cnt, 1);
    chk("fill_ready_back", mag_ready, 1);
    sweep("ramp", 0, P);

    // Overflow: second frame, then 300 surplus samples while FULL.
    send(P, P - 1, 1);
    for (int i = 0; i < 300; i++) begin
      mag_valid = 1'b1;
      mag_data  = 8'hAA;
      tick();
    end
    mag_valid = 1'b0;
    chk("ovf_ready", mag_ready, 0);
    chk("ovf_drop", drop_cnt, 255);
    read_pt("ovf_old", 0, 0);
    read_pt("ovf_old", 1, 1);
    vsync("ovf_vs", 1'b1);
    chk("ovf_swaps", swap_cnt, 2);
    sweep("ovf", 1, P);

    // Short frame of 100 points; tail must read zero.
    send(100, 99, 2);
    chk("short_ready", mag_ready, 0);
    vsync("short_vs", 1'b1);
    chk("short_swaps", swap_cnt, 3);
    for (int k = 0; k < 9; k++) begin
      vsync("probe_vs", 1'b0);
      fft_point_done = 1'b1;
      for (int s = 0; s < probes[k].idx; s++) tick();
      fft_point_done = 1'b0;
      read_pt("short", probes[k].idx, probes[k].exp);
    end
    vsync("hold_vs", 1'b0);
    read_pt("hold", 0, 1);
    data_req = 1'b0;
    fft_point_done = 1'b1;
    for (int s = 0; s < 5; s++) tick();
    fft_point_done = 1'b0;
    tick();
    chk("hold_cnt", fft_point_cnt, 6);
    chk("hold_dat", fft_data, 1);

    // Race: last sample accepted in the cycle the vsync edge is detected.
    send(P - 2, -1, 3);
    mag_valid = 1'b1; mag_data = val(3, P - 2); out_vsync = 1'b1;
    tick();
    mag_data = val(3, P - 1); mag_last = 1'b1;
    tick();
    mag_valid = 1'b0; mag_last = 1'b0;
    chk("race_swap", frame_swap, 0);
    chk("race_ready", mag_ready, 0);
    out_vsync = 1'b0;
    tick();
    chk("race_swap2", frame_swap, 0);
    tick();
    chk("race_swaps", swap_cnt, 3);
    read_pt("race_old", 0, 1);
    vsync("race_vs", 1'b1);
    chk("race_swaps2", swap_cnt, 4);
    for (int i = 0; i < 4; i++) read_pt("race_new", i, val(3, i));

    // Asynchronous reset in the middle of a partial frame.
    send(50, -1, 5);
    chk("mid_drop_pre", drop_cnt, 255);
    #3 rst = 1'b1;
    #1;
    chk("mid_ready", mag_ready, 1);
    chk("mid_cnt", fft_point_cnt, 0);
    chk("mid_data", fft_data, 0);
    chk("mid_swap", frame_swap, 0);
    chk("mid_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    read_pt("mid_pre", 0, 0);
    vsync("mid_pre_vs", 1'b0);
    send(P, P - 1, 4);
    vsync("mid_vs", 1'b1);
    chk("mid_swaps", swap_cnt, 5);
    sweep("post_rst", 4, P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
